// File: rtl/mmio_io_controller_if.sv
// CPU data-port bus between the core and the MMIO controller.
// master = CPU/memory side, slave = controller side.
interface mmio_io_controller_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [31:0] mem_rdata;
  logic        mem_write;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, write, mem_rdata,
    input  rdata, mem_write
  );

  modport slave (
    input  addr, wdata, write, mem_rdata,
    output rdata, mem_write
  );
endinterface

// File: rtl/mmio_io_controller.sv
// MMIO controller: data memory below IO_BASE, synced inputs, outputs, flags.
// Optional feature macro: SEG7_EN adds seg_out 7-seg decoders.
module mmio_io_controller #(
  parameter int ADDR_BITS = 8,
  parameter int IO_BASE   = 'hA0,
  parameter int N_IN      = 2,
  parameter int IN_W      = 5,
  parameter int N_OUT     = 3,
  parameter int OUT_W     = 14
) (
  input  logic                   clock,
  input  logic                   reset_bar,
  mmio_io_controller_if.slave    bus,
  input  logic [N_IN*IN_W-1:0]   io_in,
  output logic [N_OUT*OUT_W-1:0] io_out,
  output logic                   irq
`ifdef SEG7_EN
  ,
  output logic [N_OUT*14-1:0]    seg_out
`endif
);

  localparam int AW = ADDR_BITS;
  localparam logic [AW-1:0] BASE = AW'(IO_BASE);
  localparam int W_OUT  = 8;
  localparam int W_STAT = 16;
  localparam int W_MASK = 17;

  logic [AW-1:0] a;
  logic [AW-1:0] off;
  logic [AW-3:0] widx;
  logic          mem_sel;
  logic          io_wr;
  logic [31:0]   rd_io;

  logic [N_IN*IN_W-1:0]   s1_q, s1_d;
  logic [N_IN*IN_W-1:0]   s2_q, s2_d;
  logic [N_IN*IN_W-1:0]   prev_q, prev_d;
  logic [N_IN-1:0]        stat_q, stat_d;
  logic [N_IN-1:0]        mask_q, mask_d;
  logic [N_IN-1:0]        chg, w1c;
  logic [N_OUT*OUT_W-1:0] out_q, out_d;
  logic                   irq_q, irq_d;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:AW], bus.addr[1:0],
                         bus.wdata, off[1:0]};

  assign a       = {bus.addr[AW-1:2], 2'b00};
  assign mem_sel = a < BASE;
  assign off     = a - BASE;
  assign widx    = off[AW-1:2];
  assign io_wr   = bus.write & ~mem_sel;

  assign bus.mem_write = bus.write & mem_sel;
  assign bus.rdata     = mem_sel ? bus.mem_rdata : rd_io;
  assign io_out        = out_q;
  assign irq           = irq_q;

  // Next state: sync chain, register writes, sticky flags, irq.
  always_comb begin
    s1_d   = io_in;
    s2_d   = s1_q;
    prev_d = s2_q;
    out_d  = out_q;
    mask_d = mask_q;
    w1c    = '0;
    chg    = '0;
    for (int k = 0; k < N_IN; k++)
      chg[k] = s2_q[k*IN_W +: IN_W] != prev_q[k*IN_W +: IN_W];
    for (int k = 0; k < N_OUT; k++)
      if (io_wr && int'(widx) == W_OUT + k)
        out_d[k*OUT_W +: OUT_W] = bus.wdata[OUT_W-1:0];
    if (io_wr && int'(widx) == W_MASK)
      mask_d = bus.wdata[N_IN-1:0];
    if (io_wr && int'(widx) == W_STAT)
      w1c = bus.wdata[N_IN-1:0];
    stat_d = chg | (stat_q & ~w1c);
    irq_d  = |(stat_q & mask_q);
  end

  // I/O register read mux; unmapped offsets read as zero.
  always_comb begin
    rd_io = '0;
    for (int k = 0; k < N_IN; k++)
      if (int'(widx) == k)
        rd_io = 32'(s2_q[k*IN_W +: IN_W]);
    for (int k = 0; k < N_OUT; k++)
      if (int'(widx) == W_OUT + k)
        rd_io = 32'(out_q[k*OUT_W +: OUT_W]);
    if (int'(widx) == W_STAT)
      rd_io = 32'(stat_q);
    if (int'(widx) == W_MASK)
      rd_io = 32'(mask_q);
  end

  // State registers, all cleared by the async reset.
  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      stat_q <= '0;
      mask_q <= '0;
      out_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      stat_q <= stat_d;
      mask_q <= mask_d;
      out_q  <= out_d;
      irq_q  <= irq_d;
    end
  end

`ifdef SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return ~s;
  endfunction

  // Two active-low digits of (out_k mod 100) per output channel.
  always_comb begin
    seg_out = '1;
    for (int k = 0; k < N_OUT; k++) begin
      logic [31:0] v;
      v = 32'(out_q[k*OUT_W +: OUT_W]) % 32'd100;
      seg_out[k*14 +: 7]   = seg7(4'(v % 32'd10));
      seg_out[k*14+7 +: 7] = seg7(4'(v / 32'd10));
    end
  end
`endif

endmodule

// File: tb/tb_mmio_io_controller.sv
// Directed table plus hand sequences for mmio_io_controller.
// Default geometry: 2 x 5-bit inputs, 3 x 14-bit outputs.
module tb_mmio_io_controller;
  localparam logic [31:0] MEMV = 32'hDEADBEEF;

  logic        clock;
  logic        reset_bar;
  logic [9:0]  io_in;
  logic [41:0] io_out;
  logic        irq;
`ifdef SEG7_EN
  logic [41:0] seg_out;
`endif

  int errors = 0;
  int checks = 0;

  mmio_io_controller_if bus_if ();

  mmio_io_controller dut (
    .clock     (clock),
    .reset_bar (reset_bar),
    .bus       (bus_if),
    .io_in     (io_in),
    .io_out    (io_out),
    .irq       (irq)
`ifdef SEG7_EN
    ,
    .seg_out   (seg_out)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rd;
    logic        mw;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_chk(input logic [31:0] ad, input logic [31:0] exp,
                        input string n);
    bus_if.addr = ad;
    #1;
    chk(n, 64'(bus_if.rdata), 64'(exp));
  endtask

  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    bus_if.addr  = ad;
    bus_if.wdata = d;
    bus_if.write = 1'b1;
    cyc();
    bus_if.write = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h09C, 32'h1234,  1'b1, MEMV,         1'b1};
    vecs[1]  = '{32'h0C4, 32'h0ABC,  1'b1, 32'h0,        1'b0};
    vecs[2]  = '{32'h0C4, 32'h0,     1'b0, 32'h0ABC,     1'b0};
    vecs[3]  = '{32'h0C0, 32'h0,     1'b0, 32'h0,        1'b0};
    vecs[4]  = '{32'h0C0, 32'h3FFFF, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{32'h0C2, 32'h0,     1'b0, 32'h3FFF,     1'b0};
    vecs[6]  = '{32'h0C8, 32'h0,     1'b0, 32'h0,        1'b0};
    vecs[7]  = '{32'h0CC, 32'h5555,  1'b1, 32'h0,        1'b0};
    vecs[8]  = '{32'h0CC, 32'h0,     1'b0, 32'h0,        1'b0};
    vecs[9]  = '{32'h0E4, 32'h3,     1'b1, 32'h0,        1'b0};
    vecs[10] = '{32'h0E4, 32'h0,     1'b0, 32'h3,        1'b0};
    vecs[11] = '{32'h0D0, 32'hFF,    1'b1, 32'h0,        1'b0};
    vecs[12] = '{32'h0D0, 32'h0,     1'b0, 32'h0,        1'b0};
    vecs[13] = '{32'h1C4, 32'h0,     1'b0, 32'h0ABC,     1'b0};
    vecs[14] = '{32'h11C, 32'h0,     1'b0, MEMV,         1'b0};
    vecs[15] = '{32'h0E0, 32'h3,     1'b1, 32'h0,        1'b0};
    vecs[16] = '{32'h0E0, 32'h0,     1'b0, 32'h0,        1'b0};
    vecs[17] = '{32'h0A0, 32'h0,     1'b0, 32'h0,        1'b0};

    reset_bar        = 1'b0;
    io_in            = '0;
    bus_if.addr      = '0;
    bus_if.wdata     = '0;
    bus_if.write     = 1'b0;
    bus_if.mem_rdata = MEMV;
    repeat (2) cyc();
    chk("rst_io_out", 64'(io_out), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    reset_bar = 1'b1;
    cyc();

    for (int i = 0; i < 18; i++) begin
      bus_if.addr  = vecs[i].addr;
      bus_if.wdata = vecs[i].wdata;
      bus_if.write = vecs[i].wr;
      #1;
      chk($sformatf("vec%0d_rdata", i), 64'(bus_if.rdata),
          64'(vecs[i].rd));
      chk($sformatf("vec%0d_mem_write", i), 64'(bus_if.mem_write),
          64'(vecs[i].mw));
      cyc();
      bus_if.write = 1'b0;
    end
    chk("map_io_out", 64'(io_out), 64'({14'h0, 14'h0ABC, 14'h3FFF}));
    chk("map_irq", 64'(irq), 64'h0);

    io_in = 10'h015;
    cyc();
    rd_chk(32'hA0, 32'h0, "in_1clk");
    cyc();
    rd_chk(32'hA0, 32'h15, "in_2clk");
    rd_chk(32'hE0, 32'h0, "stat_2clk");
    cyc();
    rd_chk(32'hE0, 32'h1, "stat_3clk");
    chk("irq_3clk", 64'(irq), 64'h0);
    cyc();
    chk("irq_4clk", 64'(irq), 64'h1);

    #1 reset_bar = 1'b0;
    #1;
    chk("mid_rst_io_out", 64'(io_out), 64'h0);
    chk("mid_rst_irq", 64'(irq), 64'h0);
    rd_chk(32'hE4, 32'h0, "mid_rst_mask");
    rd_chk(32'hE0, 32'h0, "mid_rst_stat");
    rd_chk(32'hA0, 32'h0, "mid_rst_in0");
    @(negedge clock);
    reset_bar = 1'b1;
    cyc();
    cyc();
    rd_chk(32'hA0, 32'h15, "post_rst_in0");
    rd_chk(32'hE0, 32'h0, "post_rst_stat_2");
    cyc();
    rd_chk(32'hE0, 32'h1, "post_rst_stat_3");

    io_in = 10'h00A;
    cyc();
    cyc();
    wr(32'hE0, 32'h1);
    rd_chk(32'hE0, 32'h1, "w1c_collision");
    wr(32'hE0, 32'h1);
    rd_chk(32'hE0, 32'h0, "w1c_clear");
    wr(32'hE0, 32'h1);
    rd_chk(32'hE0, 32'h0, "w1c_already_clear");

    io_in = {5'h1F, 5'h0A};
    cyc();
    cyc();
    rd_chk(32'hA4, 32'h1F, "in1_2clk");
    cyc();
    rd_chk(32'hE0, 32'h2, "stat_ch1");
    wr(32'hE4, 32'h2);
    chk("irq_mask_1clk", 64'(irq), 64'h0);
    cyc();
    chk("irq_mask_2clk", 64'(irq), 64'h1);
    wr(32'hE4, 32'h0);
    chk("irq_unmask_1clk", 64'(irq), 64'h1);
    cyc();
    chk("irq_unmask_2clk", 64'(irq), 64'h0);

`ifdef SEG7_EN
    wr(32'hC0, 32'd47);
    chk("seg_47", 64'(seg_out[13:0]), 64'({7'b0011001, 7'b1111000}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
